sev_seg_scan: RTL and testbench

SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

---
 rtl/sev_seg_scan.sv | 148 ++++++++++++++
 tb/tb_sev_seg_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan.sv
// Multiplexed seven-segment digit scanner with a serial binary-to-BCD converter.
// A binary value is converted one bit per cycle (double dabble) and then copied
// atomically into a display register. The display register is scanned one digit
// at a time, with optional leading-zero blanking.
//
// Handshake: a transfer happens on a rising edge where in_valid=1 and
// in_ready=1; in_data is captured on that edge. in_ready is high only while the
// converter is idle. in_valid seen while busy is ignored, so the producer must
// hold its data until in_ready returns high.
module sev_seg_scan #(
  parameter int NDIG        = 4,
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int LZB         = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        digit_code,
  output logic [NDIG-1:0]   digit_en,
  output logic              ovf
);

  localparam int BCD_W = 4 * NDIG;
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Largest value that fits in NDIG decimal digits.
  function automatic logic [DATA_W:0] max_value();
    logic [DATA_W:0] r;
    logic [DATA_W:0] ten;
    ten = (DATA_W + 1)'(10);
    r   = (DATA_W + 1)'(1);
    for (int i = 0; i < NDIG; i++) r = r * ten;
    return r - (DATA_W + 1)'(1);
  endfunction

  localparam logic [DATA_W:0] MAX_VAL = max_value();

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BCD_W-1:0]  disp;
  logic [PS_W-1:0]   presc;
  logic [IDX_W-1:0]  idx;
  logic [NDIG-1:0]   blank;
  logic              zero_above;
  logic              out_of_range;

  assign in_ready     = (state == IDLE);
  assign out_of_range = ({1'b0, in_data} > MAX_VAL);

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | BCD_W'(shreg[DATA_W-1]);
  end

  // Converter FSM: accept, convert MSB first for DATA_W cycles, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (out_of_range) begin
              // Out-of-range values go straight to an all-blank display.
              disp <= '1;
              ovf  <= 1'b1;
            end else begin
              shreg   <= in_data;
              bcd     <= '0;
              bit_cnt <= '0;
              state   <= CONV;
            end
          end
        end
        CONV: begin
          bcd     <= bcd_next;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          disp  <= bcd;
          ovf   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh prescaler and digit index; independent of display updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_W'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit are 0.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
      blank[i]   = (LZB != 0) && (i != 0) && zero_above;
    end
  end

  // Digit select and code decoded from the registered index and display.
  always_comb begin
    digit_en   = '0;
    digit_code = 4'hF;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) begin
        digit_en[i] = 1'b1;
        digit_code  = blank[i] ? 4'hF : disp[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan with a fast refresh (4 clocks per digit).
module tb_sev_seg_scan;

  localparam int NDIG = 4;
  localparam int DW   = 14;
  localparam int RDIV = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    digit_code;
  logic [NDIG-1:0] digit_en;
  logic          ovf;

  int checks;
  int errors;

  sev_seg_scan #(
    .NDIG(NDIG), .DATA_W(DW), .REFRESH_DIV(RDIV), .LZB(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .digit_code(digit_code), .digit_en(digit_en), .ovf(ovf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected code of digit idx when the display holds decimal value v.
  function automatic logic [3:0] exp_code(input int v, input bit of, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (of) return 4'hF;
    if (idx != 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Position of the single set bit, or -1 when not one-hot.
  function automatic int en_index(input logic [NDIG-1:0] en);
    int r;
    int n;
    r = -1;
    n = 0;
    for (int i = 0; i < NDIG; i++) if (en[i] === 1'b1) begin r = i; n++; end
    if (n != 1) r = -1;
    return r;
  endfunction

  // Driver: present v and hold it until a transfer edge; returns 1 ns after it.
  task automatic send(input int v);
    int t;
    logic [31:0] vv;
    vv = v;
    t = 0;
    in_valid = 1'b1;
    in_data  = vv[DW-1:0];
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL send_timeout value=%0d in_ready=%b required=1", v, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Follows one conversion from the transfer edge: old value shown while busy,
  // busy for exactly 15 cycles, new value on the current digit right after.
  task automatic wait_conversion(input int old_v, input bit old_of, input int new_v);
    int low;
    int ix;
    low = 0;
    while (low < 40) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      low++;
      ix = en_index(digit_en);
      checks++;
      if (ix < 0 || digit_code !== exp_code(old_v, old_of, ix)) begin
        errors++;
        $display("FAIL busy_display en=%b code=%h old=%0d", digit_en, digit_code, old_v);
      end
    end
    checks++;
    if (low != 15) begin
      errors++;
      $display("FAIL busy_cycles got=%0d required=15 value=%0d", low, new_v);
    end
    ix = en_index(digit_en);
    checks++;
    if (ix < 0 || digit_code !== exp_code(new_v, 1'b0, ix)) begin
      errors++;
      $display("FAIL load_latency en=%b code=%h value=%0d", digit_en, digit_code, new_v);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after_load got=%b required=0", ovf);
    end
  endtask

  // Scans all digits four times, checking each sample against the value.
  task automatic scan_display(input int v, input bit of, input string tag);
    int ix;
    int seen;
    seen = 0;
    for (int k = 0; k < 4 * NDIG * RDIV; k++) begin
      @(negedge clk);
      ix = en_index(digit_en);
      if (ix >= 0) seen = seen | (1 << ix);
      checks++;
      if (ix < 0 || digit_code !== exp_code(v, of, ix) || in_ready !== 1'b1 || ovf !== of) begin
        errors++;
        $display("FAIL %s en=%b code=%h ovf=%b ready=%b value=%0d", tag, digit_en,
                 digit_code, ovf, in_ready, v);
      end
    end
    checks++;
    if (seen != (1 << NDIG) - 1) begin
      errors++;
      $display("FAIL %s_coverage seen=%b required=1111", tag, seen[NDIG-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || digit_en !== 4'b0001 || digit_code !== 4'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values ready=%b en=%b code=%h ovf=%b required 1 0001 0 0",
               in_ready, digit_en, digit_code, ovf);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Idle scan right after reset release: index advances every 4 clocks.
  task automatic test_scan();
    int ix;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ix = (k / RDIV) % NDIG;
      checks++;
      if (digit_en !== 4'(1 << ix) || digit_code !== ((ix == 0) ? 4'h0 : 4'hF)) begin
        errors++;
        $display("FAIL idle_scan k=%0d en=%b code=%h required_idx=%0d", k, digit_en,
                 digit_code, ix);
      end
    end
  endtask

  task automatic test_convert_1234();
    send(1234);
    wait_conversion(0, 1'b0, 1234);
    scan_display(1234, 1'b0, "show_1234");
  endtask

  task automatic test_overflow();
    send(9999);
    wait_conversion(1234, 1'b0, 9999);
    scan_display(9999, 1'b0, "show_9999");
    send(10000);
    checks++;
    if (ovf !== 1'b1 || in_ready !== 1'b1 || digit_code !== 4'hF) begin
      errors++;
      $display("FAIL ovf_immediate ovf=%b ready=%b code=%h required 1 1 f", ovf, in_ready,
               digit_code);
    end
    scan_display(0, 1'b1, "show_ovf");
  endtask

  task automatic test_blanking();
    send(5);
    wait_conversion(0, 1'b1, 5);
    scan_display(5, 1'b0, "show_5");
    send(0);
    wait_conversion(5, 1'b0, 0);
    scan_display(0, 1'b0, "show_0");
    send(1000);
    wait_conversion(0, 1'b0, 1000);
    scan_display(1000, 1'b0, "show_1000");
  endtask

  // A second value held valid during a conversion waits for in_ready.
  task automatic test_back_to_back();
    send(4321);
    in_valid = 1'b1;
    in_data  = 14'd777;
    wait_conversion(1000, 1'b0, 4321);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_conversion(4321, 1'b0, 777);
    scan_display(777, 1'b0, "show_777");
  endtask

  task automatic test_reset_mid_conv();
    send(4321);
    repeat (5) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_reset ready=%b required=0", in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || digit_en !== 4'b0001 || digit_code !== 4'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ready=%b en=%b code=%h ovf=%b required 1 0001 0 0",
               in_ready, digit_en, digit_code, ovf);
    end
    #2;
    rst_n = 1'b1;
    scan_display(0, 1'b0, "after_abort");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_convert_1234();
    test_overflow();
    test_blanking();
    test_back_to_back();
    test_reset_mid_conv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
